// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: wraps a byte stream in preamble/SFD, zero padding, CRC-32 FCS and
// inter-frame gap, and serialises it as LSB-first dibits on the 50MHz reference clock.
module rmii_tx_framer #(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned MIN_FRAME      = 60,
    parameter int unsigned IFG_BYTES      = 12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    input  logic       i_s_last,
    output logic       o_s_ready,
    output logic       o_tx_en,
    output logic       o_tx0,
    output logic       o_tx1,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_t;

    localparam logic [15:0] PreLast = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] IfgLast = 16'(IFG_BYTES - 1);
    localparam logic [10:0] MinLen  = 11'(MIN_FRAME);

    state_t      r_state, w_state_d;
    logic [1:0]  r_dib, w_dib_d;
    logic [15:0] r_cnt, w_cnt_d;
    logic [10:0] r_len, w_len_d;
    logic        r_last_taken, w_last_d;
    logic [7:0]  r_byte, w_byte_d;
    logic [31:0] r_crc, w_crc_d;
    logic        r_tx_en, w_tx_en_d;
    logic [1:0]  r_txd, w_txd_d;
    logic        r_frame_done;
    logic        r_underrun;

    logic        w_wrap;
    logic        w_ready;
    logic        w_accept;
    logic        w_abort;
    logic [31:0] w_fcs;
    logic [4:0]  w_fcs_idx;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 2; i++) begin
            if (x[0] ^ d[i]) begin
                x = (x >> 1) ^ 32'hEDB8_8320;
            end else begin
                x = x >> 1;
            end
        end
        return x;
    endfunction

    // State and dibit counter describe the dibit currently on the pins
    assign w_wrap   = (r_dib == 2'd3);
    assign w_ready  = ((r_state == StSfd) || (r_state == StData)) && w_wrap && !r_last_taken;
    assign w_accept = w_ready && i_s_valid;
    assign w_abort  = w_ready && !i_s_valid;

    always_comb begin
        w_state_d = r_state;
        w_dib_d   = r_dib + 2'd1;
        w_cnt_d   = r_cnt;
        w_len_d   = r_len;
        w_last_d  = r_last_taken;
        w_byte_d  = r_byte;

        if (w_accept) begin
            w_byte_d = i_s_data;
            w_last_d = i_s_last;
            if (r_len != 11'h7FF) begin
                w_len_d = r_len + 11'd1;
            end
        end

        case (r_state)
            StIdle: begin
                w_dib_d = 2'd0;
                if (i_s_valid) begin
                    w_state_d = StPreamble;
                    w_cnt_d   = '0;
                    w_len_d   = '0;
                    w_last_d  = 1'b0;
                end
            end
            StPreamble: begin
                if (w_wrap) begin
                    if (r_cnt == PreLast) begin
                        w_state_d = StSfd;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
            end
            StSfd: begin
                if (w_wrap) begin
                    w_cnt_d   = '0;
                    w_state_d = w_abort ? StIfg : StData;
                end
            end
            StData: begin
                if (w_wrap) begin
                    w_cnt_d = '0;
                    if (r_last_taken) begin
                        w_state_d = (r_len < MinLen) ? StPad : StFcs;
                    end else if (w_abort) begin
                        w_state_d = StIfg;
                    end
                end
            end
            StPad: begin
                if (w_wrap) begin
                    w_len_d = r_len + 11'd1;
                    if ((r_len + 11'd1) >= MinLen) begin
                        w_state_d = StFcs;
                    end
                end
            end
            StFcs: begin
                if (w_wrap) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_state_d = StIfg;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
            end
            StIfg: begin
                if (w_wrap) begin
                    if (r_cnt == IfgLast) begin
                        w_cnt_d = '0;
                        // A waiting frame starts straight out of the gap
                        if (i_s_valid) begin
                            w_state_d = StPreamble;
                            w_len_d   = '0;
                            w_last_d  = 1'b0;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 16'd1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        case (r_state)
            StData, StPad: w_crc_d = crc_dibit(r_crc, r_txd);
            StFcs:         w_crc_d = r_crc;
            default:       w_crc_d = 32'hFFFF_FFFF;
        endcase
    end

    // Output registers are loaded with the dibit belonging to the next position
    always_comb begin
        w_fcs     = ~w_crc_d;
        w_fcs_idx = {w_cnt_d[1:0], w_dib_d, 1'b0};
        w_tx_en_d = 1'b1;
        w_txd_d   = 2'b00;
        case (w_state_d)
            StPreamble: w_txd_d = 2'b01;
            StSfd:      w_txd_d = (w_dib_d == 2'd3) ? 2'b11 : 2'b01;
            StData:     w_txd_d = w_byte_d[{w_dib_d, 1'b0} +: 2];
            StPad:      w_txd_d = 2'b00;
            StFcs:      w_txd_d = w_fcs[w_fcs_idx +: 2];
            default:    w_tx_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_dib        <= 2'd0;
            r_cnt        <= '0;
            r_len        <= '0;
            r_last_taken <= 1'b0;
            r_byte       <= '0;
            r_crc        <= 32'hFFFF_FFFF;
            r_tx_en      <= 1'b0;
            r_txd        <= 2'b00;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_dib        <= w_dib_d;
            r_cnt        <= w_cnt_d;
            r_len        <= w_len_d;
            r_last_taken <= w_last_d;
            r_byte       <= w_byte_d;
            r_crc        <= w_crc_d;
            r_tx_en      <= w_tx_en_d;
            r_txd        <= w_txd_d;
            r_frame_done <= (r_state == StFcs) && w_wrap && (r_cnt[1:0] == 2'd3);
            r_underrun   <= w_abort;
        end
    end

    assign o_s_ready    = w_ready;
    assign o_tx_en      = r_tx_en;
    assign o_tx0        = r_txd[0];
    assign o_tx1        = r_txd[1];
    assign o_busy       = (r_state != StIdle);
    assign o_frame_done = r_frame_done;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Testbench for rmii_tx_framer: table of single frames plus hand-written back-to-back,
// underrun and mid-frame reset sequences, checked against a byte-level frame model.
module tb_rmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       drv_last;
    logic       mon_sel;

    always #10 clk = ~clk;

    logic d0_valid, d1_valid;
    logic rdy0, en0, t00, t01, busy0, fd0, ur0;
    logic rdy1, en1, t10, t11, busy1, fd1, ur1;

    assign d0_valid = drv_valid & ~mon_sel;
    assign d1_valid = drv_valid & mon_sel;

    rmii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME(0), .IFG_BYTES(12)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_s_data(drv_data), .i_s_valid(d0_valid),
        .i_s_last(drv_last), .o_s_ready(rdy0), .o_tx_en(en0), .o_tx0(t00), .o_tx1(t01),
        .o_busy(busy0), .o_frame_done(fd0), .o_underrun(ur0)
    );

    rmii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME(60), .IFG_BYTES(12)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_s_data(drv_data), .i_s_valid(d1_valid),
        .i_s_last(drv_last), .o_s_ready(rdy1), .o_tx_en(en1), .o_tx0(t10), .o_tx1(t11),
        .o_busy(busy1), .o_frame_done(fd1), .o_underrun(ur1)
    );

    logic       m_en, m_rdy, m_busy, m_fd, m_ur;
    logic [1:0] m_txd;
    assign m_en   = mon_sel ? en1 : en0;
    assign m_rdy  = mon_sel ? rdy1 : rdy0;
    assign m_busy = mon_sel ? busy1 : busy0;
    assign m_fd   = mon_sel ? fd1 : fd0;
    assign m_ur   = mon_sel ? ur1 : ur0;
    assign m_txd  = mon_sel ? {t11, t10} : {t01, t00};

    int n_tests = 0;
    int n_fail  = 0;

    // Stream source and expected-byte model
    logic [7:0] st_data [0:511];
    bit         st_last [0:511];
    int         st_n;
    int         gap_idx;
    int         gap_skip;
    int         exp_q[$];

    // Monitor state
    int         cap_q[$];
    int         runs_q[$];
    int         gaps_q[$];
    int         run_len, gap_len, dpos;
    logic [7:0] sh;
    int         n_acc, n_rdy, n_fd, n_ur, n_bad_txd, n_bad_fd, n_act;
    logic       prev_en;
    bit         have_run;

    typedef struct {
        bit sel;
        int len;
        int kind;
        int exp_en;
        int exp_rdy;
    } vec_t;

    vec_t vecs [0:6];

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic clr();
        cap_q.delete();
        runs_q.delete();
        gaps_q.delete();
        run_len = 0; gap_len = 0; dpos = 0; sh = 8'h00;
        n_acc = 0; n_rdy = 0; n_fd = 0; n_ur = 0;
        n_bad_txd = 0; n_bad_fd = 0; n_act = 0;
        prev_en = 1'b0; have_run = 1'b0;
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic step();
        @(negedge clk);
        if (m_rdy) n_rdy++;
        if (m_rdy && drv_valid) n_acc++;
        if (m_en || m_busy || m_rdy) n_act++;
        if (m_fd) begin
            n_fd++;
            if (m_en || !prev_en) n_bad_fd++;
        end
        if (m_ur) n_ur++;
        if (m_en) begin
            if (!prev_en && have_run) gaps_q.push_back(gap_len);
            run_len++;
            sh = {m_txd, sh[7:2]};
            if (dpos == 3) begin
                cap_q.push_back(int'(sh));
                dpos = 0;
            end else begin
                dpos++;
            end
        end else begin
            if (m_txd != 2'b00) n_bad_txd++;
            if (prev_en) begin
                runs_q.push_back(run_len);
                run_len  = 0;
                have_run = 1'b1;
                gap_len  = 0;
                dpos     = 0;
            end
            gap_len++;
        end
        prev_en = m_en;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        end
        return x;
    endfunction

    task automatic add_frame(input int kind, input int len);
        logic [71:0] s;
        logic [7:0]  b;
        s = "123456789";
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       b = s[8*(8-i) +: 8];
                1:       b = 8'(i + 1);
                default: b = 8'((i * 37 + 5) & 255);
            endcase
            st_data[st_n] = b;
            st_last[st_n] = (i == len - 1);
            st_n++;
        end
    endtask

    task automatic exp_frame(input int minf, input int start, input int len, input bit partial);
        logic [31:0] c;
        int          n;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(int'(st_data[start+i]));
            c = crc_byte(c, st_data[start+i]);
        end
        if (!partial) begin
            n = len;
            while (n < minf) begin
                exp_q.push_back(0);
                c = crc_byte(c, 8'h00);
                n++;
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back(int'((c >> (8 * k)) & 32'hFF));
        end
    endtask

    task automatic check_bytes(input string name);
        int bad;
        int n;
        bad = 0;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap_q[i] != exp_q[i]) begin
                if (bad == 0) $display("  %s byte %0d: got %02h want %02h", name, i, cap_q[i], exp_q[i]);
                bad++;
            end
        end
        check({name, "_count"}, cap_q.size(), exp_q.size());
        check(name, bad, 0);
    endtask

    // Feed the stream, returning once the wanted pulses are seen and the DUT is idle again
    task automatic run_stream(input int want_fd, input int want_ur, input int stop_acc);
        int idx, skip, idle, cyc;
        bit gdone, done;
        skip = 0; idle = 0; gdone = 0; done = 0;
        for (cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (!gdone && gap_idx >= 0 && n_ur > 0) begin
                skip  = gap_skip - n_acc;
                gdone = 1;
            end
            idx = n_acc + skip;
            if (idx < st_n && !(idx == gap_idx && !gdone)) begin
                drv_valid = 1'b1;
                drv_data  = st_data[idx];
                drv_last  = st_last[idx];
            end else begin
                drv_valid = 1'b0;
                drv_data  = 8'h00;
                drv_last  = 1'b0;
            end
            step();
            if (stop_acc > 0) begin
                if (n_acc >= stop_acc) done = 1;
            end else if (n_fd >= want_fd && n_ur >= want_ur && (n_acc + skip) >= st_n && !m_busy) begin
                idle++;
                if (idle >= 4) done = 1;
            end
        end
        if (!done) check("stream_timeout", cyc, -1);
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    initial begin
        longint fcs_got;
        int     nb;

        vecs[0] = '{sel: 1'b0, len: 9,  kind: 0, exp_en: 84,  exp_rdy: 9};
        vecs[1] = '{sel: 1'b1, len: 14, kind: 1, exp_en: 288, exp_rdy: 14};
        vecs[2] = '{sel: 1'b1, len: 60, kind: 2, exp_en: 288, exp_rdy: 60};
        vecs[3] = '{sel: 1'b1, len: 61, kind: 2, exp_en: 292, exp_rdy: 61};
        vecs[4] = '{sel: 1'b0, len: 1,  kind: 1, exp_en: 52,  exp_rdy: 1};
        vecs[5] = '{sel: 1'b1, len: 59, kind: 1, exp_en: 288, exp_rdy: 59};
        vecs[6] = '{sel: 1'b0, len: 64, kind: 2, exp_en: 304, exp_rdy: 64};

        drv_valid = 1'b0; drv_data = 8'h00; drv_last = 1'b0; mon_sel = 1'b1;
        gap_idx = -1; gap_skip = 0; st_n = 0;
        clr();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {en0, t00, t01, rdy0, busy0, fd0, ur0}, 0);
        check("reset_dut1", {en1, t10, t11, rdy1, busy1, fd1, ur1}, 0);
        rst = 1'b0;

        // Idle with s_valid low
        clr();
        repeat (100) step();
        check("idle_activity", n_act, 0);
        check("idle_runs", runs_q.size(), 0);

        foreach (vecs[v]) begin
            mon_sel = vecs[v].sel;
            st_n = 0;
            add_frame(vecs[v].kind, vecs[v].len);
            exp_q.delete();
            exp_frame(vecs[v].sel ? 60 : 0, 0, vecs[v].len, 1'b0);
            gap_idx = -1;
            clr();
            run_stream(1, 0, 0);
            check($sformatf("v%0d_txen_cycles", v), (runs_q.size() > 0) ? runs_q[0] : -1,
                  vecs[v].exp_en);
            check($sformatf("v%0d_ready_count", v), n_rdy, vecs[v].exp_rdy);
            check($sformatf("v%0d_frame_done", v), n_fd, 1);
            check($sformatf("v%0d_underrun", v), n_ur, 0);
            check($sformatf("v%0d_txd_fd_timing", v), n_bad_txd + n_bad_fd, 0);
            check_bytes($sformatf("v%0d_bytes", v));
            if (vecs[v].kind == 0) begin
                nb = cap_q.size();
                fcs_got = -1;
                if (nb >= 4) begin
                    fcs_got = 0;
                    for (int k = 1; k <= 4; k++) fcs_got = (fcs_got << 8) | cap_q[nb-k];
                end
                check("fcs_123456789", fcs_got, 64'h0000_0000_CBF4_3926);
            end
        end

        // Back-to-back 60-byte frames with s_valid held high
        mon_sel = 1'b1;
        st_n = 0;
        add_frame(2, 60);
        add_frame(1, 60);
        exp_q.delete();
        exp_frame(60, 0, 60, 1'b0);
        exp_frame(60, 60, 60, 1'b0);
        gap_idx = -1;
        clr();
        run_stream(2, 0, 0);
        check("b2b_run0", (runs_q.size() > 0) ? runs_q[0] : -1, 288);
        check("b2b_run1", (runs_q.size() > 1) ? runs_q[1] : -1, 288);
        check("b2b_gap", (gaps_q.size() > 0) ? gaps_q[0] : -1, 48);
        check("b2b_frame_done", n_fd, 2);
        check_bytes("b2b_bytes");

        // Underrun on the 5th byte, then a 20-byte frame
        st_n = 0;
        add_frame(1, 10);
        add_frame(2, 20);
        exp_q.delete();
        exp_frame(60, 0, 4, 1'b1);
        exp_frame(60, 10, 20, 1'b0);
        gap_idx = 4;
        gap_skip = 10;
        clr();
        run_stream(1, 1, 0);
        check("ur_run0", (runs_q.size() > 0) ? runs_q[0] : -1, 48);
        check("ur_pulse_cycles", n_ur, 1);
        check("ur_gap", (gaps_q.size() > 0) ? gaps_q[0] : -1, 48);
        check("ur_run1", (runs_q.size() > 1) ? runs_q[1] : -1, 288);
        check("ur_frame_done", n_fd, 1);
        check("ur_fd_timing", n_bad_fd + n_bad_txd, 0);
        check_bytes("ur_bytes");

        // Reset in the middle of a data byte
        st_n = 0;
        add_frame(2, 30);
        gap_idx = -1;
        clr();
        run_stream(0, 0, 3);
        drv_valid = 1'b1;
        drv_data  = st_data[3];
        drv_last  = 1'b0;
        step();
        check("pre_reset_txen", en1, 1);
        #3 rst = 1'b1;
        #1;
        check("reset_mid_frame", {en1, t10, t11, rdy1, busy1}, 0);
        drv_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        st_n = 0;
        add_frame(1, 30);
        exp_q.delete();
        exp_frame(60, 0, 30, 1'b0);
        clr();
        run_stream(1, 0, 0);
        check("post_reset_run", (runs_q.size() > 0) ? runs_q[0] : -1, 288);
        check("post_reset_fd_ur", n_fd * 16 + n_ur, 16);
        check_bytes("post_reset_bytes");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
